run_length_encoder: RTL

- Downstream stage of data_store; consumes the same (data_start, data) sample stream that data_store sees.
- Compresses consecutive equal 16-bit samples into (value, count) pairs.
- Buffers pairs in a small show-ahead FIFO with a valid/ready output handshake toward the next consumer.
- The input has no backpressure, so FIFO overflow is detected and flagged.

---
 rtl/run_length_encoder_pkg.sv | 14 +
 rtl/run_length_encoder_fifo.sv | 65 ++++++
 rtl/run_length_encoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/run_length_encoder_pkg.sv
// Shared definitions for the run-length encoder: FSM encodings and default widths.
// Pairs are packed as {value, count}, value in the MSBs, DATA_W+CNT_W bits wide.
package run_length_encoder_pkg;

  localparam int RLE_DATA_W = 16;
  localparam int RLE_CNT_W  = 4;
  localparam int RLE_DEPTH  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rle_state_e;

endpackage

// File: rtl/run_length_encoder_fifo.sv
// Show-ahead synchronous FIFO holding packed (value, count) pairs.
// Pushes while full are ignored unless a pop happens on the same edge.
module rle_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  // When full, the write lands in the slot the simultaneous pop vacates.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/run_length_encoder.sv
// Run-length encoder: folds equal consecutive samples into (value, count) pairs
// and queues them for a valid/ready consumer; drops and flags pairs when full.
module run_length_encoder
  import run_length_encoder_pkg::*;
#(
  parameter int DATA_W = RLE_DATA_W,
  parameter int CNT_W  = RLE_CNT_W,
  parameter int DEPTH  = RLE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_start,
  input  logic [DATA_W-1:0]        data,
  input  logic                     rle_ready,
  output logic                     rle_valid,
  output logic [DATA_W-1:0]        rle_value,
  output logic [CNT_W-1:0]         rle_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PAIR_W = DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rle_state_e        state_q, state_d;
  logic [DATA_W-1:0] cur_value_q, cur_value_d;
  logic [CNT_W-1:0]  cur_count_q, cur_count_d;
  logic              overflow_q, overflow_d;

  logic              pair_push;
  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [PAIR_W-1:0] fifo_dout;

  always_comb begin
    state_d     = state_q;
    cur_value_d = cur_value_q;
    cur_count_d = cur_count_q;
    pair_push   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_start) begin
          cur_value_d = data;
          cur_count_d = CNT_W'(1);
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!data_start) begin
          pair_push = 1'b1;
          state_d   = ST_IDLE;
        end else if (data != cur_value_q) begin
          pair_push   = 1'b1;
          cur_value_d = data;
          cur_count_d = CNT_W'(1);
        end else if (cur_count_q == CNT_MAX) begin
          // Saturated run: emit a full pair and keep counting the same value.
          pair_push   = 1'b1;
          cur_count_d = CNT_W'(1);
        end else begin
          cur_count_d = cur_count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_pop   = !fifo_empty && rle_ready;
  assign fifo_push  = pair_push && (!fifo_full || fifo_pop);
  assign overflow_d = overflow_q | (pair_push && fifo_full && !fifo_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_value_q <= '0;
      cur_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_value_q <= cur_value_d;
      cur_count_q <= cur_count_d;
      overflow_q  <= overflow_d;
    end
  end

  rle_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   ({cur_value_q, cur_count_q}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign rle_valid = !fifo_empty;
  assign rle_value = fifo_dout[PAIR_W-1:CNT_W];
  assign rle_count = fifo_dout[CNT_W-1:0];
  assign overflow  = overflow_q;

endmodule
